// File: rtl/reorder_buffer_pkg.sv
// Shared types and constants for the reorder buffer: entry layout, depth and tag widths.
// Optional performance counters in reorder_buffer are enabled with `define ROB_PERF_EN.
package reorder_buffer_pkg;

  localparam int ROB_DEPTH = 32;
  localparam int IDX_W     = $clog2(ROB_DEPTH);
  localparam int CNT_W     = IDX_W + 1;
  localparam int PREG_W    = 7;

  typedef struct packed {
    logic              valid;
    logic              done;
    logic              has_dest;
    logic [PREG_W-1:0] pd_new;
    logic [PREG_W-1:0] pd_old;
  } rob_entry_t;

  // Position of a tag relative to head in program order; 0 is the oldest entry.
  function automatic logic [IDX_W-1:0] rob_age(input logic [IDX_W-1:0] tag,
                                               input logic [IDX_W-1:0] head);
    return tag - head;
  endfunction

endpackage

// File: rtl/reorder_buffer.sv
// Circular in-order retirement queue with completion tracking and mispredict flush.
// `define ROB_PERF_EN adds saturating perf_commits / perf_full_stalls counters.
module reorder_buffer
  import reorder_buffer_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
`ifdef ROB_PERF_EN
  output logic [31:0]       perf_commits,
  output logic [31:0]       perf_full_stalls,
`endif
  input  logic              alloc_valid,
  input  logic [PREG_W-1:0] alloc_pd_new,
  input  logic [PREG_W-1:0] alloc_pd_old,
  input  logic              alloc_has_dest,
  output logic              rob_full,
  output logic [IDX_W-1:0]  rob_index_in,
  input  logic              cmp_alu_valid,
  input  logic [IDX_W-1:0]  cmp_alu_tag,
  input  logic              cmp_mem_valid,
  input  logic [IDX_W-1:0]  cmp_mem_tag,
  input  logic              cmp_b_valid,
  input  logic [IDX_W-1:0]  cmp_b_tag,
  input  logic              cmp_b_mispredict,
  output logic              mispredict,
  output logic [IDX_W-1:0]  mispredict_tag,
  output logic              commit_valid,
  output logic [PREG_W-1:0] commit_pd_old,
  output logic [PREG_W-1:0] commit_pd_new,
  output logic              commit_has_dest
);

  rob_entry_t        entries_q [ROB_DEPTH];
  rob_entry_t        entries_d [ROB_DEPTH];
  logic [IDX_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              mispredict_q, mispredict_d;
  logic [IDX_W-1:0]  mispredict_tag_q, mispredict_tag_d;
  logic              commit_valid_q, commit_valid_d;
  logic [PREG_W-1:0] commit_pd_old_q, commit_pd_old_d;
  logic [PREG_W-1:0] commit_pd_new_q, commit_pd_new_d;
  logic              commit_has_dest_q, commit_has_dest_d;
  logic              flush, commit_pop, alloc_acc;
`ifdef ROB_PERF_EN
  logic [31:0]       perf_commits_q, perf_commits_d;
  logic [31:0]       perf_full_stalls_q, perf_full_stalls_d;
`endif

  assign rob_full        = (count_q == CNT_W'(ROB_DEPTH));
  assign rob_index_in    = tail_q;
  assign mispredict      = mispredict_q;
  assign mispredict_tag  = mispredict_tag_q;
  assign commit_valid    = commit_valid_q;
  assign commit_pd_old   = commit_pd_old_q;
  assign commit_pd_new   = commit_pd_new_q;
  assign commit_has_dest = commit_has_dest_q;

  // Next-state computation: completions, flush mask, allocation, retirement.
  always_comb begin
    entries_d  = entries_q;
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    flush      = cmp_b_valid & cmp_b_mispredict;
    commit_pop = entries_q[head_q].valid & entries_q[head_q].done;
    alloc_acc  = alloc_valid & ~rob_full & ~flush;

    if (cmp_alu_valid && entries_q[cmp_alu_tag].valid) entries_d[cmp_alu_tag].done = 1'b1;
    else                                               entries_d[cmp_alu_tag].done = entries_q[cmp_alu_tag].done;
    if (cmp_mem_valid && entries_q[cmp_mem_tag].valid) entries_d[cmp_mem_tag].done = 1'b1;
    else                                               entries_d[cmp_mem_tag].done = entries_d[cmp_mem_tag].done;
    if (cmp_b_valid && entries_q[cmp_b_tag].valid)     entries_d[cmp_b_tag].done   = 1'b1;
    else                                               entries_d[cmp_b_tag].done   = entries_d[cmp_b_tag].done;

    if (flush) begin
      // Younger-than-branch entries are squashed after completions so late done bits are dropped.
      for (int i = 0; i < ROB_DEPTH; i++) begin
        if (rob_age(IDX_W'(i), head_q) > rob_age(cmp_b_tag, head_q)) begin
          entries_d[i].valid = 1'b0;
          entries_d[i].done  = 1'b0;
        end else begin
          entries_d[i] = entries_d[i];
        end
      end
      tail_d  = cmp_b_tag + IDX_W'(1);
      count_d = CNT_W'(rob_age(cmp_b_tag, head_q)) + CNT_W'(1) - CNT_W'(commit_pop);
    end else begin
      if (alloc_acc) begin
        entries_d[tail_q] = '{valid: 1'b1, done: 1'b0, has_dest: alloc_has_dest,
                              pd_new: alloc_pd_new, pd_old: alloc_pd_old};
        tail_d = tail_q + IDX_W'(1);
      end else begin
        tail_d = tail_q;
      end
      count_d = count_q + CNT_W'(alloc_acc) - CNT_W'(commit_pop);
    end

    if (commit_pop) begin
      entries_d[head_q].valid = 1'b0;
      entries_d[head_q].done  = 1'b0;
      head_d                  = head_q + IDX_W'(1);
      commit_pd_old_d         = entries_q[head_q].pd_old;
      commit_pd_new_d         = entries_q[head_q].pd_new;
      commit_has_dest_d       = entries_q[head_q].has_dest;
    end else begin
      commit_pd_old_d         = '0;
      commit_pd_new_d         = '0;
      commit_has_dest_d       = 1'b0;
    end
    commit_valid_d   = commit_pop;
    mispredict_d     = flush;
    mispredict_tag_d = flush ? cmp_b_tag : '0;

`ifdef ROB_PERF_EN
    if (commit_pop && perf_commits_q != 32'hFFFF_FFFF) perf_commits_d = perf_commits_q + 32'd1;
    else                                               perf_commits_d = perf_commits_q;
    if (alloc_valid && rob_full && perf_full_stalls_q != 32'hFFFF_FFFF)
      perf_full_stalls_d = perf_full_stalls_q + 32'd1;
    else
      perf_full_stalls_d = perf_full_stalls_q;
`endif
  end

  // State and registered outputs, synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      entries_q         <= '{default: '0};
      head_q            <= '0;
      tail_q            <= '0;
      count_q           <= '0;
      mispredict_q      <= 1'b0;
      mispredict_tag_q  <= '0;
      commit_valid_q    <= 1'b0;
      commit_pd_old_q   <= '0;
      commit_pd_new_q   <= '0;
      commit_has_dest_q <= 1'b0;
`ifdef ROB_PERF_EN
      perf_commits_q     <= 32'd0;
      perf_full_stalls_q <= 32'd0;
`endif
    end else begin
      entries_q         <= entries_d;
      head_q            <= head_d;
      tail_q            <= tail_d;
      count_q           <= count_d;
      mispredict_q      <= mispredict_d;
      mispredict_tag_q  <= mispredict_tag_d;
      commit_valid_q    <= commit_valid_d;
      commit_pd_old_q   <= commit_pd_old_d;
      commit_pd_new_q   <= commit_pd_new_d;
      commit_has_dest_q <= commit_has_dest_d;
`ifdef ROB_PERF_EN
      perf_commits_q     <= perf_commits_d;
      perf_full_stalls_q <= perf_full_stalls_d;
`endif
    end
  end

`ifdef ROB_PERF_EN
  assign perf_commits     = perf_commits_q;
  assign perf_full_stalls = perf_full_stalls_q;
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios plus a randomized run
// against a program-order queue model.
module tb_reorder_buffer;
  import reorder_buffer_pkg::*;

  logic              clk = 1'b0;
  logic              reset;
  logic              alloc_valid, alloc_has_dest;
  logic [PREG_W-1:0] alloc_pd_new, alloc_pd_old;
  logic              rob_full;
  logic [IDX_W-1:0]  rob_index_in;
  logic              cmp_alu_valid, cmp_mem_valid, cmp_b_valid, cmp_b_mispredict;
  logic [IDX_W-1:0]  cmp_alu_tag, cmp_mem_tag, cmp_b_tag;
  logic              mispredict;
  logic [IDX_W-1:0]  mispredict_tag;
  logic              commit_valid, commit_has_dest;
  logic [PREG_W-1:0] commit_pd_old, commit_pd_new;
`ifdef ROB_PERF_EN
  logic [31:0]       perf_commits, perf_full_stalls;
`endif

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    int                tag;
    logic [PREG_W-1:0] pn;
    logic [PREG_W-1:0] po;
    logic              hd;
    bit                done;
  } ment_t;
  ment_t mq[$];

  reorder_buffer dut (
    .clk(clk), .reset(reset),
`ifdef ROB_PERF_EN
    .perf_commits(perf_commits), .perf_full_stalls(perf_full_stalls),
`endif
    .alloc_valid(alloc_valid), .alloc_pd_new(alloc_pd_new), .alloc_pd_old(alloc_pd_old),
    .alloc_has_dest(alloc_has_dest), .rob_full(rob_full), .rob_index_in(rob_index_in),
    .cmp_alu_valid(cmp_alu_valid), .cmp_alu_tag(cmp_alu_tag),
    .cmp_mem_valid(cmp_mem_valid), .cmp_mem_tag(cmp_mem_tag),
    .cmp_b_valid(cmp_b_valid), .cmp_b_tag(cmp_b_tag), .cmp_b_mispredict(cmp_b_mispredict),
    .mispredict(mispredict), .mispredict_tag(mispredict_tag),
    .commit_valid(commit_valid), .commit_pd_old(commit_pd_old),
    .commit_pd_new(commit_pd_new), .commit_has_dest(commit_has_dest)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    alloc_valid = 1'b0; alloc_pd_new = '0; alloc_pd_old = '0; alloc_has_dest = 1'b0;
    cmp_alu_valid = 1'b0; cmp_alu_tag = '0; cmp_mem_valid = 1'b0; cmp_mem_tag = '0;
    cmp_b_valid = 1'b0; cmp_b_tag = '0; cmp_b_mispredict = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    mq.delete();
  endtask

  task automatic alloc_one(input int po, input int pn);
    idle();
    alloc_valid = 1'b1; alloc_pd_old = PREG_W'(po); alloc_pd_new = PREG_W'(pn); alloc_has_dest = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    idle();
    alloc_valid = 1'b1;
    reset = 1'b1;
    tick(); tick();
    n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b want=0", rob_full); end
    n_cmp++; if (rob_index_in !== 5'd0) begin n_fail++; $display("FAIL reset_index got=%0d want=0", rob_index_in); end
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL reset_commit got=%b want=0", commit_valid); end
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL reset_mispredict got=%b want=0", mispredict); end
    reset = 1'b0;
    tick(); tick(); tick();
    n_cmp++; if (rob_index_in !== 5'd3) begin n_fail++; $display("FAIL prereset_index got=%0d want=3", rob_index_in); end
    reset = 1'b1;
    tick();
    n_cmp++; if (rob_index_in !== 5'd0) begin n_fail++; $display("FAIL midreset_index got=%0d want=0", rob_index_in); end
    reset = 1'b0;
    idle();
    tick();
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL midreset_commit got=%b want=0", commit_valid); end
  endtask

  task automatic test_in_order();
    do_reset();
    alloc_one(1, 5); alloc_one(2, 6); alloc_one(3, 7);
    idle(); cmp_alu_valid = 1'b1; cmp_alu_tag = 5'd1; tick();
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL order_early1 got=%b want=0", commit_valid); end
    idle(); cmp_mem_valid = 1'b1; cmp_mem_tag = 5'd0; tick();
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL order_early2 got=%b want=0", commit_valid); end
    idle(); tick();
    n_cmp++; if (commit_valid !== 1'b1 || commit_pd_old !== 7'd1 || commit_pd_new !== 7'd5)
      begin n_fail++; $display("FAIL order_c0 got=%b/%0d/%0d want=1/1/5", commit_valid, commit_pd_old, commit_pd_new); end
    tick();
    n_cmp++; if (commit_valid !== 1'b1 || commit_pd_old !== 7'd2 || commit_has_dest !== 1'b1)
      begin n_fail++; $display("FAIL order_c1 got=%b/%0d/%b want=1/2/1", commit_valid, commit_pd_old, commit_has_dest); end
    tick();
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL order_tag2 got=%b want=0", commit_valid); end
  endtask

  task automatic test_fill();
    do_reset();
    for (int i = 0; i < 31; i++) alloc_one(i, i);
    n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL fill31 got=%b want=0", rob_full); end
    alloc_one(31, 31);
    n_cmp++; if (rob_full !== 1'b1 || rob_index_in !== 5'd0)
      begin n_fail++; $display("FAIL fill32 got=%b/%0d want=1/0", rob_full, rob_index_in); end
    alloc_one(99, 99);
    n_cmp++; if (rob_full !== 1'b1 || rob_index_in !== 5'd0)
      begin n_fail++; $display("FAIL fill33 got=%b/%0d want=1/0", rob_full, rob_index_in); end
    cmp_alu_valid = 1'b1; cmp_alu_tag = 5'd0; tick();
    cmp_alu_valid = 1'b0;
    tick();
    n_cmp++; if (commit_valid !== 1'b1 || rob_full !== 1'b0 || rob_index_in !== 5'd0)
      begin n_fail++; $display("FAIL fill_commit got=%b/%b/%0d want=1/0/0", commit_valid, rob_full, rob_index_in); end
    tick();
    n_cmp++; if (rob_full !== 1'b1 || rob_index_in !== 5'd1)
      begin n_fail++; $display("FAIL fill_refill got=%b/%0d want=1/1", rob_full, rob_index_in); end
  endtask

  task automatic test_wrap();
    int tg;
    logic [PREG_W-1:0] exp_po;
    do_reset();
    for (int i = 0; i < 30; i++) alloc_one(i, i);
    for (int i = 0; i < 30; i++) begin
      idle(); cmp_alu_valid = 1'b1; cmp_alu_tag = IDX_W'(i); tick();
    end
    idle(); tick(); tick();
    n_cmp++; if (rob_index_in !== 5'd30 || rob_full !== 1'b0)
      begin n_fail++; $display("FAIL wrap_head got=%0d/%b want=30/0", rob_index_in, rob_full); end
    for (int k = 0; k < 4; k++) begin
      tg = (30 + k) % 32;
      n_cmp++; if (rob_index_in !== IDX_W'(tg)) begin n_fail++; $display("FAIL wrap_tag got=%0d want=%0d", rob_index_in, tg); end
      alloc_one(tg + 40, tg);
    end
    for (int k = 0; k < 4; k++) begin
      tg = (33 - k) % 32;
      idle(); cmp_alu_valid = 1'b1; cmp_alu_tag = IDX_W'(tg); tick();
      n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_early got=%b want=0", commit_valid); end
    end
    idle();
    for (int k = 0; k < 4; k++) begin
      tg = (30 + k) % 32;
      exp_po = PREG_W'(tg + 40);
      tick();
      n_cmp++; if (commit_valid !== 1'b1 || commit_pd_old !== exp_po)
        begin n_fail++; $display("FAIL wrap_commit got=%b/%0d want=1/%0d", commit_valid, commit_pd_old, exp_po); end
    end
  endtask

  task automatic test_flush();
    do_reset();
    for (int i = 0; i < 6; i++) alloc_one(10 + i, i);
    idle(); cmp_b_valid = 1'b1; cmp_b_mispredict = 1'b1; cmp_b_tag = 5'd2; tick();
    n_cmp++; if (mispredict !== 1'b1 || mispredict_tag !== 5'd2 || rob_index_in !== 5'd3)
      begin n_fail++; $display("FAIL flush_pulse got=%b/%0d/%0d want=1/2/3", mispredict, mispredict_tag, rob_index_in); end
    idle(); cmp_alu_valid = 1'b1; cmp_alu_tag = 5'd4; tick();
    n_cmp++; if (mispredict !== 1'b0) begin n_fail++; $display("FAIL flush_oneshot got=%b want=0", mispredict); end
    alloc_one(33, 3);
    n_cmp++; if (rob_index_in !== 5'd4) begin n_fail++; $display("FAIL flush_realloc got=%0d want=4", rob_index_in); end
    idle(); cmp_alu_valid = 1'b1; cmp_alu_tag = 5'd0; cmp_mem_valid = 1'b1; cmp_mem_tag = 5'd1; tick();
    idle();
    for (int k = 0; k < 3; k++) begin
      tick();
      n_cmp++; if (commit_valid !== 1'b1 || commit_pd_old !== PREG_W'(10 + k))
        begin n_fail++; $display("FAIL flush_commit%0d got=%b/%0d want=1/%0d", k, commit_valid, commit_pd_old, 10 + k); end
    end
    tick();
    n_cmp++; if (commit_valid !== 1'b0) begin n_fail++; $display("FAIL flush_stale got=%b want=0", commit_valid); end
  endtask

  task automatic test_flush_commit();
    do_reset();
    alloc_one(20, 0); alloc_one(21, 1); alloc_one(22, 2);
    idle(); cmp_alu_valid = 1'b1; cmp_alu_tag = 5'd0; tick();
    idle(); cmp_b_valid = 1'b1; cmp_b_mispredict = 1'b1; cmp_b_tag = 5'd1; tick();
    n_cmp++; if (commit_valid !== 1'b1 || commit_pd_old !== 7'd20 || mispredict !== 1'b1 || rob_index_in !== 5'd2)
      begin n_fail++; $display("FAIL fc_edge got=%b/%0d/%b/%0d want=1/20/1/2", commit_valid, commit_pd_old, mispredict, rob_index_in); end
    idle(); tick();
    n_cmp++; if (commit_valid !== 1'b1 || commit_pd_old !== 7'd21)
      begin n_fail++; $display("FAIL fc_branch got=%b/%0d want=1/21", commit_valid, commit_pd_old); end
    for (int i = 0; i < 31; i++) alloc_one(i, i);
    n_cmp++; if (rob_full !== 1'b0) begin n_fail++; $display("FAIL fc_count31 got=%b want=0", rob_full); end
    alloc_one(0, 0);
    n_cmp++; if (rob_full !== 1'b1) begin n_fail++; $display("FAIL fc_count32 got=%b want=1", rob_full); end
  endtask

  function automatic int find_tag(input logic [IDX_W-1:0] t);
    for (int k = 0; k < mq.size(); k++) if (mq[k].tag == int'(t)) return k;
    return -1;
  endfunction

  function automatic logic [IDX_W-1:0] pick_tag();
    if (mq.size() > 0 && $urandom_range(0, 3) != 0) return IDX_W'(mq[$urandom_range(0, mq.size() - 1)].tag);
    return IDX_W'($urandom);
  endfunction

  task automatic test_random();
    int m_tail, sz0, fi, ap, cp;
    bit pop, fl;
    ment_t e_c, ne;
    logic [IDX_W-1:0] ftag;
    do_reset();
    m_tail = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      ap = ((cyc / 150) % 2 == 0) ? 80 : 25;
      cp = ((cyc / 150) % 2 == 0) ? 20 : 70;
      idle();
      alloc_valid = ($urandom_range(0, 99) < ap);
      alloc_pd_new = PREG_W'($urandom); alloc_pd_old = PREG_W'($urandom); alloc_has_dest = 1'($urandom);
      if ($urandom_range(0, 99) < cp) begin cmp_alu_valid = 1'b1; cmp_alu_tag = pick_tag(); end
      if ($urandom_range(0, 99) < cp) begin cmp_mem_valid = 1'b1; cmp_mem_tag = pick_tag(); end
      if ($urandom_range(0, 4) == 0) begin
        cmp_b_valid = 1'b1; cmp_b_tag = pick_tag();
        fi = find_tag(cmp_b_tag);
        if (fi >= 0 && !mq[fi].done && $urandom_range(0, 7) == 0) cmp_b_mispredict = 1'b1;
      end
      @(posedge clk);
      sz0 = mq.size();
      pop = (sz0 > 0) && mq[0].done;
      if (pop) e_c = mq[0];
      fl = cmp_b_valid && cmp_b_mispredict;
      ftag = cmp_b_tag;
      if (fl) begin
        fi = find_tag(cmp_b_tag);
        while (mq.size() > fi + 1) void'(mq.pop_back());
        mq[fi].done = 1'b1;
        m_tail = (int'(cmp_b_tag) + 1) % ROB_DEPTH;
      end
      for (int k = 0; k < mq.size(); k++) begin
        if ((cmp_alu_valid && mq[k].tag == int'(cmp_alu_tag)) || (cmp_mem_valid && mq[k].tag == int'(cmp_mem_tag)) ||
            (cmp_b_valid && mq[k].tag == int'(cmp_b_tag))) mq[k].done = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (alloc_valid && sz0 < ROB_DEPTH && !fl) begin
        ne.tag = m_tail; ne.pn = alloc_pd_new; ne.po = alloc_pd_old; ne.hd = alloc_has_dest; ne.done = 1'b0;
        mq.push_back(ne);
        m_tail = (m_tail + 1) % ROB_DEPTH;
      end
      #1;
      n_cmp++; if (commit_valid !== pop) begin n_fail++; $display("FAIL rnd_commit cyc=%0d got=%b want=%b", cyc, commit_valid, pop); end
      if (pop) begin
        n_cmp++; if (commit_pd_old !== e_c.po || commit_pd_new !== e_c.pn || commit_has_dest !== e_c.hd)
          begin n_fail++; $display("FAIL rnd_cdata cyc=%0d got=%0d/%0d/%b want=%0d/%0d/%b", cyc,
                 commit_pd_old, commit_pd_new, commit_has_dest, e_c.po, e_c.pn, e_c.hd); end
      end
      n_cmp++; if (mispredict !== fl) begin n_fail++; $display("FAIL rnd_mispredict cyc=%0d got=%b want=%b", cyc, mispredict, fl); end
      if (fl) begin
        n_cmp++; if (mispredict_tag !== ftag) begin n_fail++; $display("FAIL rnd_mtag cyc=%0d got=%0d want=%0d", cyc, mispredict_tag, ftag); end
      end
      n_cmp++; if (rob_full !== (mq.size() == ROB_DEPTH)) begin n_fail++; $display("FAIL rnd_full cyc=%0d got=%b want=%b", cyc, rob_full, mq.size() == ROB_DEPTH); end
      n_cmp++; if (rob_index_in !== IDX_W'(m_tail)) begin n_fail++; $display("FAIL rnd_index cyc=%0d got=%0d want=%0d", cyc, rob_index_in, m_tail); end
    end
  endtask

  initial begin
    idle();
    reset = 1'b1;
    test_reset();
    test_in_order();
    test_fill();
    test_wrap();
    test_flush();
    test_flush_commit();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
